irq_pending_ctrl: RTL and testbench

- Request-capture stage directly upstream of the 7:1 priorityencoder.
- Latches seven raw interrupt lines (edge- or level-sensitive per line) into a pending register and gates them with an enable mask.
- The masked vector feeds priorityencoder; the resulting 3-bit id goes out on a valid/ready handshake.
- Acceptance of an id clears that line's pending bit.

---
 rtl/irq_pkg.sv | 12 +
 rtl/priorityencoder.sv | 12 +
 rtl/irq_pending_ctrl.sv | 94 +++++++++
 tb/tb_irq_pending_ctrl.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/irq_pkg.sv
// Shared types for the interrupt request-capture stage and its encoder.
package irq_pkg;
  localparam int NUM_IRQ = 7;

  typedef logic [7:1] irq_vec_t;
  typedef logic [2:0] irq_id_t;

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } irq_state_t;
endpackage

// File: rtl/priorityencoder.sv
// 7:1 priority encoder: highest set index wins, 0 when no line is set.
module priorityencoder (
  input  logic [7:1] a,
  output logic [2:0] y
);
  always_comb begin
    y = 3'd0;
    for (int i = 1; i <= 7; i++) begin
      if (a[i]) y = 3'(i);
    end
  end
endmodule

// File: rtl/irq_pending_ctrl.sv
// Captures raw interrupt lines into a pending register, masks them and offers
// the highest-priority pending id on a valid/ready handshake.
module irq_pending_ctrl
  import irq_pkg::*;
#(
  parameter irq_vec_t LEVEL_MASK = 7'b0000000,
  parameter irq_vec_t ENABLE_RST = 7'b1111111
) (
  input  logic       clk,
  input  logic       reset,
  input  irq_vec_t   irq,
  input  logic       en_we,
  input  irq_vec_t   en_wdata,
  output irq_vec_t   enable,
  input  logic       ovf_clr,
  output irq_vec_t   ovf,
  output irq_vec_t   pend_vec,
  output logic       id_valid,
  output irq_id_t    id,
  input  logic       id_ready,
  output irq_state_t state_dbg
);
  // Handshake: an id transfers on a rising edge where id_valid && id_ready;
  // once id_valid is high, id is held stable until that transfer.

  irq_vec_t   irq_q, pend_q, pend_d, en_q, en_d, ovf_q, ovf_d;
  irq_vec_t   set_v, clr_v, new_ovf;
  irq_id_t    id_q, id_d, enc_id;
  irq_state_t state_q, state_d;
  logic       accept;

  priorityencoder u_enc (
    .a (pend_vec),
    .y (enc_id)
  );

  assign pend_vec  = pend_q & en_q;
  assign enable    = en_q;
  assign ovf       = ovf_q;
  assign id        = id_q;
  assign id_valid  = (state_q == OFFER);
  assign state_dbg = state_q;
  assign accept    = id_valid && id_ready;

  assign set_v = (LEVEL_MASK & irq) | (~LEVEL_MASK & irq & ~irq_q);

  always_comb begin
    clr_v = '0;
    for (int i = 1; i <= NUM_IRQ; i++) begin
      if (accept && (id_q == irq_id_t'(i))) clr_v[i] = 1'b1;
    end
  end

  // A fresh request always re-pends, even on the cycle its old copy is acked.
  assign pend_d  = set_v | (pend_q & ~clr_v);
  assign new_ovf = set_v & pend_q & ~clr_v & ~LEVEL_MASK;
  assign ovf_d   = new_ovf | (ovf_clr ? '0 : ovf_q);
  assign en_d    = en_we ? en_wdata : en_q;

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    unique case (state_q)
      IDLE: begin
        if (pend_vec != '0) begin
          id_d    = enc_id;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (id_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      irq_q   <= '0;
      pend_q  <= '0;
      en_q    <= ENABLE_RST;
      ovf_q   <= '0;
      id_q    <= '0;
      state_q <= IDLE;
    end else begin
      irq_q   <= irq;
      pend_q  <= pend_d;
      en_q    <= en_d;
      ovf_q   <= ovf_d;
      id_q    <= id_d;
      state_q <= state_d;
    end
  end
endmodule

// File: tb/tb_irq_pending_ctrl.sv
// Bench for irq_pending_ctrl: directed scenarios plus random traffic against
// a behavioural model; offered ids flow through an expected-id queue.
module tb_irq_pending_ctrl;
  import irq_pkg::*;

  localparam logic [7:1] LEVEL = 7'b0000001;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:1] irq, en_wdata, enable, ovf, pend_vec;
  logic       en_we, ovf_clr, id_valid, id_ready;
  logic [2:0] id;
  irq_state_t state_dbg;

  irq_pending_ctrl #(.LEVEL_MASK(LEVEL), .ENABLE_RST(7'h7F)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .en_we     (en_we),
    .en_wdata  (en_wdata),
    .enable    (enable),
    .ovf_clr   (ovf_clr),
    .ovf       (ovf),
    .pend_vec  (pend_vec),
    .id_valid  (id_valid),
    .id        (id),
    .id_ready  (id_ready),
    .state_dbg (state_dbg)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  bit m_pend[1:7], m_ovf[1:7], m_en[1:7], m_prev[1:7];
  int m_offer = 0;            // id currently on offer, 0 = nothing offered
  logic [2:0] exp_q[$];

  int n_checks = 0, n_err = 0;
  bit mon_en = 0;

  task automatic model_edge();
    bit old_pend[1:7];
    bit old_en[1:7];
    int acked;
    if (reset) begin
      for (int i = 1; i <= 7; i++) begin
        m_pend[i] = 0; m_ovf[i] = 0; m_en[i] = 1; m_prev[i] = 0;
      end
      m_offer = 0;
      return;
    end
    old_pend = m_pend;
    old_en   = m_en;
    acked = (m_offer != 0 && id_ready) ? m_offer : 0;
    for (int i = 1; i <= 7; i++) begin
      bit rise;
      bit cleared;
      rise    = LEVEL[i] ? irq[i] : (irq[i] && !m_prev[i]);
      cleared = (acked == i);
      m_ovf[i]  = (rise && old_pend[i] && !cleared && !LEVEL[i]) || (m_ovf[i] && !ovf_clr);
      m_pend[i] = rise || (old_pend[i] && !cleared);
      if (en_we) m_en[i] = en_wdata[i];
      m_prev[i] = irq[i];
    end
    if (m_offer != 0) begin
      if (id_ready) m_offer = 0;
    end else begin
      for (int i = 1; i <= 7; i++)
        if (old_pend[i] && old_en[i]) m_offer = i;
      if (m_offer != 0) exp_q.push_back(3'(m_offer));
    end
  endtask

  function automatic logic [7:1] pack(input bit v[1:7]);
    logic [7:1] r;
    for (int i = 1; i <= 7; i++) r[i] = v[i];
    return r;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, req);
    end
  endtask

  // ---------------- monitor / scoreboard ----------------
  logic       prev_valid = 1'b0;
  logic [2:0] cur_exp = 3'd0;

  always @(negedge clk) begin
    if (mon_en) begin
      check("id_valid", {7'd0, id_valid}, {7'd0, m_offer != 0});
      check("pend_vec", {1'b0, pend_vec}, {1'b0, pack(m_pend) & pack(m_en)});
      check("ovf", {1'b0, ovf}, {1'b0, pack(m_ovf)});
      check("enable", {1'b0, enable}, {1'b0, pack(m_en)});
      if (id_valid && !prev_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_offer", {5'd0, id}, 8'd0);
          cur_exp = id;
        end else begin
          cur_exp = exp_q.pop_front();
        end
      end
      if (id_valid) check("id", {5'd0, id}, {5'd0, cur_exp});
      prev_valid = id_valid;
    end
  end

  // ---------------- driver ----------------
  task automatic step(input logic [7:1] irq_v, input logic rdy, input logic we,
                      input logic [7:1] wd, input logic oc, input logic rst);
    irq = irq_v; id_ready = rdy; en_we = we; en_wdata = wd; ovf_clr = oc; reset = rst;
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle(input int n, input logic rdy);
    for (int k = 0; k < n; k++) step(7'd0, rdy, 1'b0, 7'd0, 1'b0, 1'b0);
  endtask

  initial begin
    // reset
    step(7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
    mon_en = 1;
    step(7'd0, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
    idle(2, 1'b1);

    // single edge on line 5
    step(7'b0010000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(4, 1'b1);

    // priority hold: 3 and 6 together, then 7 arrives during the offer
    step(7'b0100100, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(7'b1000000, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(4, 1'b0);
    idle(8, 1'b1);

    // masking keeps line 3 waiting until re-enabled
    step(7'b0000100, 1'b1, 1'b1, 7'b1111011, 1'b0, 1'b0);
    idle(5, 1'b1);
    step(7'd0, 1'b1, 1'b1, 7'h7F, 1'b0, 1'b0);
    idle(3, 1'b1);

    // overflow on line 2, then clear
    step(7'b0000010, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(1, 1'b0);
    step(7'b0000010, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    idle(3, 1'b1);
    step(7'd0, 1'b1, 1'b0, 7'd0, 1'b1, 1'b0);
    idle(2, 1'b1);

    // new edge on 6 coincides with accept of 6
    step(7'b0100000, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(2, 1'b0);
    step(7'b0100000, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
    idle(5, 1'b1);

    // level line 1 held high, then reset during an offer
    for (int k = 0; k < 7; k++) step(7'b0000001, 1'b1, 1'b0, 7'd0, 1'b0, 1'b0);
    step(7'b0000001, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    step(7'b0000001, 1'b0, 1'b0, 7'd0, 1'b0, 1'b0);
    step(7'b0000001, 1'b0, 1'b0, 7'd0, 1'b0, 1'b1);
    idle(3, 1'b1);

    // random traffic
    for (int k = 0; k < 600; k++) begin
      logic [7:1] r;
      for (int b = 1; b <= 7; b++) r[b] = ($urandom_range(0, 3) == 0);
      step(r, 1'($urandom_range(0, 1)),
           ($urandom_range(0, 15) == 0), 7'($urandom_range(0, 127)),
           ($urandom_range(0, 9) == 0), ($urandom_range(0, 99) == 0));
    end
    step(7'd0, 1'b0, 1'b1, 7'h7F, 1'b0, 1'b0);
    idle(20, 1'b1);

    @(negedge clk);
    #1;
    check("exp_q_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
